sha256_round_engine: RTL
========================

# sha256_round_engine

Iterative SHA-256 compression engine that consumes the 32-bit T2 term (Sigma0(a) + Maj(a,b,c)) logic and its T1 counterpart once per round. It holds working registers a..h and runs 64 rounds per 512-bit block. Each round takes one message-schedule word W_t from the upstream scheduler through a valid/ready handshake. It sits between the message scheduler (upstream) and the nonce/compare logic (downstream), and returns the block's updated hash state.

## Interface
Parameters:
- ROUNDS, 64, rounds per block; only 64 is supported, the parameter exists for bench shortening.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a block; honoured only in IDLE.
- hash_in  in  256  chaining value H0..H7; H0 = [255:224], H7 = [31:0].
- w_in  in  32  message schedule word W_t.
- w_valid  in  1  w_in is valid.
- w_ready  out  1  engine accepts W_t this cycle.
- hash_out  out  256  result, same packing as hash_in.
- out_valid  out  1  hash_out is valid; held until accepted.
- out_ready  in  1  downstream accepts hash_out.
- busy  out  1  high in every state except IDLE.

## Operation
- Four states: IDLE, ROUND, FINAL, DONE.
- IDLE → ROUND on start:
  - Latch hash_in into h_save[255:0] and into a..h.
  - Clear round counter t (7 bits).
- ROUND:
  - w_ready = 1.
  - On each w_valid && w_ready handshake, perform one round using K_t from an internal 64-entry constant ROM indexed by t:
    - T1 = h + Sigma1(e) + Ch(e,f,g) + K_t + W_t.
    - T2 = Sigma0(a) + Maj(a,b,c).
    - Update: h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2.
  - Then t←t+1.
  - With w_valid low, the registers and t hold.
  - After the handshake at t = ROUNDS-1 → FINAL.
- FINAL (one cycle): register hash_out (see Configuration) → DONE.
- DONE:
  - out_valid = 1.
  - On out_valid && out_ready → IDLE.
  - hash_out stays stable until accepted.
- Arithmetic is modulo 2^32 throughout; carries are discarded.
  - Sigma0 = ROTR2^ROTR13^ROTR22.
  - Sigma1 = ROTR6^ROTR11^ROTR25.
  - Ch = (e&f)^(~e&g).
  - Maj = (a&b)^(a&c)^(b&c).
- Boundary conditions:
  - start outside IDLE is ignored, with no effect on state.
  - start and out_ready together in DONE: the result is accepted and the start is ignored. One IDLE cycle is required before the next start.
  - w_valid outside ROUND is ignored, and w_ready = 0.
  - Reset asserted mid-block aborts immediately; no partial result is emitted.

## Timing
- Reset values:
  - State IDLE; t = 0.
  - a..h = 0; h_save = 0.
  - hash_out = 0; out_valid = 0; w_ready = 0; busy = 0.
- start sampled at edge E0 → busy and w_ready high after E0.
- With w_valid held high, W_0..W_63 are accepted at edges E1..E64 (one round per cycle).
- FINAL occupies the cycle after E64.
- out_valid rises after E66: 66 cycles from start plus the number of w_valid-low stall cycles.
- The earliest next start is the cycle after the out_valid && out_ready edge plus one IDLE cycle.
- All outputs are registered; no combinational path from inputs to outputs except none (w_ready depends only on state).

## Configuration
- SHA256_FEEDFORWARD_EN:
  - Defined: FINAL computes hash_out word i = h_save word i + working register i (mod 2^32), i.e. a standard compression output.
  - Undefined: hash_out = raw {a,b,c,d,e,f,g,h}, and h_save is not instantiated. This supports double-SHA pipelines where the downstream stage performs the addition.

## Test plan
- Reset then idle: assert rst low mid-ROUND at t = 30 → all outputs 0, state IDLE, and a following start runs a clean block.
- Round 0 trace: start with hash_in = 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19, w_in = 61626380 → after E1, a..h = 5d6aebcd 6a09e667 bb67ae85 3c6ef372 fa2a4622 510e527f 9b05688c 1f83d9ab.
- Full "abc" block, with the schedule from the bench model and FEEDFORWARD_EN defined → hash_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; out_valid exactly 66 cycles after start.
- Random w_valid stalls (50% duty) on "abc" → same digest; latency = 66 + stall count; registers hold during stalls.
- Backpressure: out_ready low for 10 cycles in DONE → hash_out and out_valid stable; a start pulse during this window is ignored.
- FEEDFORWARD_EN undefined, "abc" block → hash_out word i = digest word i − IV word i (mod 2^32).

Source files
------------

// File: rtl/sha256_round_engine.sv
// sha256_round_engine: iterative SHA-256 compression, one round per accepted schedule word W_t.
// Ports: clk; rst (async, active-low); start (begin block, IDLE only); hash_in[255:0] (H0 in [255:224]);
//   w_in/w_valid/w_ready (schedule word handshake, ready only in ROUND);
//   hash_out/out_valid/out_ready (result handshake, held until accepted); busy (high outside IDLE).
// SHA256_FEEDFORWARD_EN: when defined, hash_out adds the chaining value to the working registers;
//   otherwise hash_out is the raw {a..h} and no chaining-value copy is kept.
module sha256_round_engine #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] hash_in,
  input  logic [31:0]  w_in,
  input  logic         w_valid,
  output logic         w_ready,
  output logic [255:0] hash_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  state_t       state_q, state_d;
  logic [6:0]   t_q, t_d;
  logic [255:0] work_q, work_d;
  logic [255:0] hash_out_q, hash_out_d;
  logic         out_valid_q, out_valid_d;
  logic         w_ready_q, w_ready_d;
  logic         busy_q, busy_d;
  logic [255:0] final_val;
  logic [31:0]  a, b, c, d, e, f, g, h;
  logic [31:0]  s0, s1, ch, maj, t1, t2;
  logic         fire, accept, launch;
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  assign {a, b, c, d, e, f, g, h} = work_q;
  assign launch = (state_q == IDLE) && start;
  assign fire   = w_ready_q && w_valid;
  // out_valid is a registered view of DONE, so the handshake uses the flop, not the state
  assign accept = out_valid_q && out_ready;
  always_comb begin
    s0  = rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22);
    s1  = rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25);
    ch  = (e & f) ^ (~e & g);
    maj = (a & b) ^ (a & c) ^ (b & c);
    t1  = h + s1 + ch + K[t_q[5:0]] + w_in;
    t2  = s0 + maj;
  end
`ifdef SHA256_FEEDFORWARD_EN
  logic [255:0] h_save_q, h_save_d;
  assign h_save_d = launch ? hash_in : h_save_q;
  always_comb begin
    final_val = '0;
    for (int i = 0; i < 8; i++) final_val[32*i +: 32] = h_save_q[32*i +: 32] + work_q[32*i +: 32];
  end
`else
  assign final_val = work_q;
`endif
  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    work_d     = work_q;
    hash_out_d = hash_out_q;
    if (launch) begin
      state_d = ROUND;
      t_d     = '0;
      work_d  = hash_in;
    end
    if (fire) begin
      work_d  = {t1 + t2, a, b, c, d + t1, e, f, g};
      t_d     = t_q + 7'd1;
      state_d = (t_q == 7'(ROUNDS - 1)) ? FINAL : ROUND;
    end
    if (state_q == FINAL) begin
      hash_out_d = final_val;
      state_d    = DONE;
    end
    if (state_q == DONE && accept) state_d = IDLE;
    out_valid_d = (state_q == DONE) && !accept;
    w_ready_d   = state_d == ROUND;
    busy_d      = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      t_q         <= '0;
      work_q      <= '0;
      hash_out_q  <= '0;
      out_valid_q <= 1'b0;
      w_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SHA256_FEEDFORWARD_EN
      h_save_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      work_q      <= work_d;
      hash_out_q  <= hash_out_d;
      out_valid_q <= out_valid_d;
      w_ready_q   <= w_ready_d;
      busy_q      <= busy_d;
`ifdef SHA256_FEEDFORWARD_EN
      h_save_q    <= h_save_d;
`endif
    end
  end
  assign hash_out  = hash_out_q;
  assign out_valid = out_valid_q;
  assign w_ready   = w_ready_q;
  assign busy      = busy_q;
endmodule
